// File: rtl/scoreboard_requester.sv
// rtl/scoreboard_requester.sv - request sequencer between a host port and a key/value scoreboard
module scoreboard_requester #(
    parameter int KEY_W = 8,
    parameter int VAL_W = 4,
    parameter int DEPTH = 4,
    parameter int TMO   = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [1:0]               i_req_op,
    input  logic [KEY_W-1:0]         i_req_key,
    input  logic [VAL_W-1:0]         i_req_val,
    output logic                     o_sb_write,
    output logic                     o_sb_read,
    output logic                     o_sb_flush,
    output logic [KEY_W+VAL_W-1:0]   o_sb_entry,
    input  logic                     i_sb_ack,
    input  logic                     i_sb_exists,
    input  logic [VAL_W-1:0]         i_sb_val,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_op,
    output logic                     o_rsp_exists,
    output logic [VAL_W-1:0]         o_rsp_val,
    output logic                     o_rsp_tmo,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic                     o_full
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(TMO) + 1;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] busy_cnt;

    assign o_full   = (o_occupancy == OCC_MAX);
    assign o_rsp_op = op_q;

    // Writes are refused while full; the reserved op is never accepted.
    always_comb begin
        o_req_ready = 1'b0;
        if (i_rstn && state == IDLE) begin
            o_req_ready = (i_req_op != 2'b00) && !(i_req_op == OP_WRITE && o_full);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= IDLE;
            op_q         <= 2'b00;
            busy_cnt     <= '0;
            o_sb_write   <= 1'b0;
            o_sb_read    <= 1'b0;
            o_sb_flush   <= 1'b0;
            o_sb_entry   <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_exists <= 1'b0;
            o_rsp_val    <= '0;
            o_rsp_tmo    <= 1'b0;
            o_occupancy  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        op_q       <= i_req_op;
                        o_sb_entry <= {i_req_key, i_req_val};
                        busy_cnt   <= '0;
                        o_sb_write <= (i_req_op == OP_WRITE);
                        o_sb_read  <= (i_req_op == OP_READ);
                        o_sb_flush <= (i_req_op == OP_FLUSH);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_sb_ack) begin
                        o_sb_write   <= 1'b0;
                        o_sb_read    <= 1'b0;
                        o_sb_flush   <= 1'b0;
                        o_rsp_exists <= (op_q == OP_WRITE) | i_sb_exists;
                        o_rsp_val    <= i_sb_val;
                        o_rsp_tmo    <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                        if (op_q == OP_WRITE && o_occupancy != OCC_MAX) begin
                            o_occupancy <= o_occupancy + OCC_W'(1);
                        end else if (op_q == OP_FLUSH && i_sb_exists && o_occupancy != '0) begin
                            o_occupancy <= o_occupancy - OCC_W'(1);
                        end
                    end else if (busy_cnt == CNT_LAST) begin
                        o_sb_write   <= 1'b0;
                        o_sb_read    <= 1'b0;
                        o_sb_flush   <= 1'b0;
                        o_rsp_exists <= 1'b0;
                        o_rsp_val    <= '0;
                        o_rsp_tmo    <= 1'b1;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= GAP;
                    end
                end
                // One idle cycle so back-to-back strobes always show a fresh rising edge.
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
